// File: rtl/fa_chk_pkg.sv
// Shared definitions for the full-adder response checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fa_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Every {a,b,cin} combination has been seen.
    localparam logic [7:0] FULL_COV = 8'hFF;

    // One-hot coverage bit for an {a,b,cin} index.
    function automatic logic [7:0] cov_bit(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Golden full adder used as the reference for observed DUT outputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs.
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_s,
    output logic exp_cout
);

    assign exp_s    = a ^ b ^ cin;
    assign exp_cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Full-adder response checker: counts pass/fail, tracks {a,b,cin} coverage, raises done at full coverage.
// Latency: results visible the cycle after accept; done rises on the edge that completes coverage.
// Backpressure: vec_ready high only in RUN; FA_CHK_TIMEOUT_EN adds an idle-timeout abort.
module fa_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             s,
    input  logic             cout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [7:0]       cov_mask,
    output logic [2:0]       first_fail_idx,
    output logic             first_fail_vld,
    output logic             done,
    output logic             all_pass,
    output logic             timeout
);

    state_t     state_q;
    state_t     state_d;
    logic       exp_s;
    logic       exp_cout;
    logic       match;
    logic       accept;
    logic [2:0] idx;
    logic [7:0] cov_next;
    logic       cov_done;
    logic       expire;

    fa_ref_model u_ref (
        .a        (a),
        .b        (b),
        .cin      (cin),
        .exp_s    (exp_s),
        .exp_cout (exp_cout)
    );

    // start wins over a same-cycle observation, which is simply dropped.
    assign idx      = {a, b, cin};
    assign match    = (s == exp_s) && (cout == exp_cout);
    assign accept   = vec_valid && vec_ready && !start;
    assign cov_next = cov_mask | cov_bit(idx);
    assign cov_done = accept && (cov_next == FULL_COV);

    assign vec_ready = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign all_pass  = done && (fail_cnt == '0) && !timeout;

`ifdef FA_CHK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer_q;
    logic             timeout_q;

    // A completing accept is never an idle cycle, so it always beats expiry.
    assign expire  = (state_q == RUN) && !start && !accept &&
                     (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    // Idle timer: counts RUN cycles without an accept, sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if (start) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (accept) begin
                timer_q <= '0;
            end else if (expire) begin
                timer_q   <= '0;
                timeout_q <= 1'b1;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start from anywhere re-enters RUN; RUN ends on coverage or expiry.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (cov_done || expire) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating counters, coverage mask and first-failure latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cov_mask       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cov_mask       <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept) begin
            cov_mask <= cov_next;
            if (match) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                if (!first_fail_vld) begin
                    first_fail_idx <= idx;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fa_resp_checker.sv
// Self-checking bench for fa_resp_checker: table-driven vectors with a scoreboard queue.
// Latency: expectations are compared 1 time unit after the rising edge that produces them.
// Backpressure: a small reference model decides acceptance from its own view of the state.
module tb_fa_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, vec_valid, a, b, cin, s, cout;
    logic       vec_ready, first_fail_vld, done, all_pass, timeout;
    logic [7:0] pass_cnt, fail_cnt, cov_mask;
    logic [2:0] first_fail_idx;

    logic       s2_start, s2_valid, s2_a, s2_b, s2_cin, s2_s, s2_cout;
    logic       d2_ready, d2_ffv, d2_done, d2_all_pass, d2_timeout;
    logic [1:0] d2_pass, d2_fail;
    logic [7:0] d2_cov;
    logic [2:0] d2_ffi;

    always #5 clk = ~clk;

    fa_resp_checker #(.CNT_W(8), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .cov_mask(cov_mask),
        .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
        .done(done), .all_pass(all_pass), .timeout(timeout)
    );

    fa_resp_checker #(.CNT_W(2), .TIMEOUT_CYC(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .vec_valid(s2_valid), .vec_ready(d2_ready),
        .a(s2_a), .b(s2_b), .cin(s2_cin), .s(s2_s), .cout(s2_cout),
        .pass_cnt(d2_pass), .fail_cnt(d2_fail), .cov_mask(d2_cov),
        .first_fail_idx(d2_ffi), .first_fail_vld(d2_ffv),
        .done(d2_done), .all_pass(d2_all_pass), .timeout(d2_timeout)
    );

    // One observation record: {a, b, cin, s, cout}.
    typedef struct packed {
        logic a, b, cin, s, cout;
    } vec_t;

    typedef struct packed {
        logic [7:0] pass;
        logic [7:0] fail;
        logic [7:0] cov;
        logic [2:0] ffi;
        logic       ffv, dn, ap, rdy, to;
    } exp_t;

    vec_t tbl[8];
    exp_t sb_q[$];

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state.
    int         m_pass, m_fail, m_state, m_idle;
    logic [7:0] m_cov;
    logic [2:0] m_ffi;
    logic       m_ffv, m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pass = 0; m_fail = 0; m_state = 0; m_idle = 0;
        m_cov = 8'h00; m_ffi = 3'd0; m_ffv = 1'b0; m_to = 1'b0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pass = 8'(m_pass);
        e.fail = 8'(m_fail);
        e.cov  = m_cov;
        e.ffi  = m_ffi;
        e.ffv  = m_ffv;
        e.dn   = (m_state == 2);
        e.rdy  = (m_state == 1);
        e.to   = m_to;
        e.ap   = (m_state == 2) && (m_fail == 0) && !m_to;
        return e;
    endfunction

    task automatic model_cycle(input logic st, input logic v, input vec_t x);
        logic [1:0] sum;
        sum = 2'(x.a) + 2'(x.b) + 2'(x.cin);
        if (st) begin
            m_pass = 0; m_fail = 0; m_cov = 8'h00; m_ffv = 1'b0; m_to = 1'b0;
            m_idle = 0; m_state = 1;
        end else if (m_state == 1) begin
            if (v) begin
                if ({x.cout, x.s} == sum) begin
                    if (m_pass < 255) m_pass++;
                end else begin
                    if (m_fail < 255) m_fail++;
                    if (!m_ffv) begin
                        m_ffv = 1'b1;
                        m_ffi = {x.a, x.b, x.cin};
                    end
                end
                m_cov[{x.a, x.b, x.cin}] = 1'b1;
                m_idle = 0;
                if (m_cov == 8'hFF) m_state = 2;
            end else begin
`ifdef FA_CHK_TIMEOUT_EN
                m_idle++;
                if (m_idle == 10) begin
                    m_to = 1'b1;
                    m_state = 2;
                end
`endif
            end
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pass"}, pass_cnt, e.pass);
            chk({tag, "_fail"}, fail_cnt, e.fail);
            chk({tag, "_cov"}, cov_mask, e.cov);
            chk({tag, "_ffv"}, first_fail_vld, e.ffv);
            if (e.ffv) chk({tag, "_ffi"}, first_fail_idx, e.ffi);
            chk({tag, "_done"}, done, e.dn);
            chk({tag, "_all_pass"}, all_pass, e.ap);
            chk({tag, "_ready"}, vec_ready, e.rdy);
            chk({tag, "_timeout"}, timeout, e.to);
        end
    endtask

    // Drive one cycle, push the expectation, compare after the edge.
    task automatic cyc(input logic st, input logic v, input vec_t x, input string tag);
        start = st; vec_valid = v;
        a = x.a; b = x.b; cin = x.cin; s = x.s; cout = x.cout;
        model_cycle(st, v, x);
        sb_q.push_back(snap());
        @(posedge clk);
        #1;
        start = 1'b0; vec_valid = 1'b0;
        compare_out(tag);
    endtask

    initial begin
        vec_t bad;
        vec_t nul;
        tbl[0] = 5'b000_00; tbl[1] = 5'b001_10; tbl[2] = 5'b010_10; tbl[3] = 5'b011_01;
        tbl[4] = 5'b100_10; tbl[5] = 5'b101_01; tbl[6] = 5'b110_01; tbl[7] = 5'b111_11;
        nul = 5'b000_00;

        rst_n = 1'b0; start = 0; vec_valid = 0; a = 0; b = 0; cin = 0; s = 0; cout = 0;
        s2_start = 0; s2_valid = 0; s2_a = 0; s2_b = 0; s2_cin = 0; s2_s = 0; s2_cout = 0;
        model_reset();
        #12;
        sb_q.push_back(snap());
        compare_out("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Observations while IDLE are ignored.
        cyc(0, 1, tbl[3], "idle_vld");
        cyc(0, 1, tbl[7], "idle_vld");

        // All 8 correct, one per cycle.
        cyc(1, 0, nul, "start1");
        for (int i = 0; i < 8; i++) cyc(0, 1, tbl[i], "allpass");
        // Observations in DONE are ignored.
        cyc(0, 1, 5'b000_11, "done_vld");

        // Vector 101 reports s=1,cout=1.
        cyc(1, 0, nul, "start2");
        for (int i = 0; i < 8; i++) begin
            bad = tbl[i];
            if (i == 5) bad = 5'b101_11;
            cyc(0, 1, bad, "onefail");
        end

        // Duplicates: 000 ten times then the rest.
        cyc(1, 0, nul, "start3");
        for (int i = 0; i < 10; i++) cyc(0, 1, tbl[0], "dup");
        for (int i = 1; i < 8; i++) cyc(0, 1, tbl[i], "dup_rest");

        // start beats a same-cycle observation.
        cyc(1, 0, nul, "start4");
        for (int i = 0; i < 3; i++) cyc(0, 1, tbl[i], "prio_pre");
        cyc(1, 1, tbl[4], "prio_start");
        cyc(0, 1, tbl[7], "prio_post");

        // CNT_W=2 instance: pass count saturates at 3.
        s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s2_valid = 1'b1;
            {s2_a, s2_b, s2_cin, s2_s, s2_cout} = tbl[i];
            @(posedge clk); #1;
            s2_valid = 1'b0;
            chk("sat_pass", d2_pass, (i + 1 > 3) ? 3 : i + 1);
        end
        chk("sat_fail", d2_fail, 0);
        chk("sat_done", d2_done, 1);
        chk("sat_all_pass", d2_all_pass, 1);

        // Asynchronous reset after 4 accepts, then a clean session.
        cyc(1, 0, nul, "start5");
        for (int i = 0; i < 4; i++) cyc(0, 1, tbl[i], "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(snap());
        compare_out("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, nul, "start6");
        for (int i = 7; i >= 0; i--) cyc(0, 1, tbl[i], "post_rst");

`ifdef FA_CHK_TIMEOUT_EN
        // Two accepts then ten idle RUN cycles.
        cyc(1, 0, nul, "start7");
        cyc(0, 1, tbl[0], "tmo_acc");
        cyc(0, 1, tbl[1], "tmo_acc");
        for (int i = 0; i < 10; i++) cyc(0, 0, nul, "tmo_idle");
        chk("tmo_flag", timeout, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
